fetch_queue: RTL and testbench

- Instruction buffer directly downstream of fetch_unit.
- Drives fetch_unit's enable/ctl_change/next_addr, captures each fetch_done/head result into a small FIFO, and presents entries to dispatch with a valid/ready handshake and pre-split MMIX fields.
- Owns redirect sequencing: it flushes stale entries and discards any in-flight fetch result that belongs to the old stream.

---
 rtl/mmix_defs.sv | 41 ++++
 rtl/sync_fifo.sv | 58 +++++
 rtl/fetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmix_defs.sv
// Shared MMIX front-end definitions: fetch record, interrupt bit positions,
// mirror FSM encoding and the instruction field splitter.
package mmix_defs;

  localparam int PX_BIT = 0;
  localparam int F_BIT  = 1;

  localparam logic [7:0] SWYM = 8'hFD;

  typedef struct packed {
    logic [63:0] loc;
    logic [31:0] inst;
    logic [7:0]  interrupt;
  } fetch;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
    logic       imm;
  } inst_fields_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_BUSY = 2'd1,
    M_COOL = 2'd2
  } mirror_state_t;

  // Opcode LSB selects the Z-immediate form for most MMIX op pairs.
  function automatic inst_fields_t split_inst(input logic [31:0] inst);
    inst_fields_t f;
    f.op  = inst[31:24];
    f.x   = inst[23:16];
    f.y   = inst[15:8];
    f.z   = inst[7:0];
    f.imm = inst[24];
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with flush; head is read combinationally from rd_ptr.
// Caller must not push when full nor pop when empty; such requests are ignored.
module sync_fifo
  import mmix_defs::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T               mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  cnt;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Flush drops every entry by snapping rd_ptr onto wr_ptr.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch_unit and dispatch: drives fetch requests,
// queues results, and sequences redirects while discarding stale fetches.
module fetch_queue
  import mmix_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     fetch_enable,
  output logic                     fetch_ctl_change,
  output logic [63:0]              fetch_next_addr,
  input  logic                     fetch_done,
  input  fetch                     fetch_head,
  input  logic                     redirect,
  input  logic [63:0]              redirect_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output fetch                     out_head,
  output logic [7:0]               out_op,
  output logic [7:0]               out_x,
  output logic [7:0]               out_y,
  output logic [7:0]               out_z,
  output logic                     out_imm,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

  mirror_state_t  mirror;
  mirror_state_t  mirror_nxt;
  logic           redir_pend;
  logic [63:0]    redir_addr;
  logic [63:0]    issued_addr;
  logic           overflow;

  logic           discard;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  count_after_pop;
  inst_fields_t   fields;

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (fetch_head),
    .pop       (pop),
    .head      (out_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Anything that completes during or after a redirect belongs to the old stream.
  assign discard         = redirect || redir_pend;
  assign out_valid       = !reset && !fifo_empty && !discard;
  assign pop             = out_valid && out_ready;
  assign push            = fetch_done && !discard && !fifo_full;
  assign count_after_pop = fifo_count - CW'(pop);
  assign count           = fifo_count;

  assign fields  = split_inst(out_head.inst);
  assign out_op  = fields.op;
  assign out_x   = fields.x;
  assign out_y   = fields.y;
  assign out_z   = fields.z;
  assign out_imm = fields.imm;

  always_ff @(posedge clk) begin
    if (reset) mirror <= M_IDLE;
    else       mirror <= mirror_nxt;
  end

  always_comb begin
    mirror_nxt = mirror;
    unique case (mirror)
      M_IDLE:  if (fetch_enable) mirror_nxt = M_BUSY;
      M_BUSY:  if (fetch_done)   mirror_nxt = M_COOL;
      M_COOL:  mirror_nxt = M_IDLE;
      default: mirror_nxt = M_IDLE;
    endcase
  end

  // One slot is always held back so the fetch in flight can land.
  always_comb begin
    fetch_enable     = 1'b0;
    fetch_ctl_change = 1'b0;
    fetch_next_addr  = issued_addr;
    if (!reset && mirror == M_IDLE && !redirect) begin
      if (redir_pend) begin
        fetch_enable     = 1'b1;
        fetch_ctl_change = 1'b1;
        fetch_next_addr  = redir_addr;
      end else if (count_after_pop <= CW'(DEPTH - 2)) begin
        fetch_enable = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redir_pend  <= 1'b0;
      redir_addr  <= '0;
      issued_addr <= '0;
      overflow    <= 1'b0;
    end else begin
      if (redirect) begin
        redir_pend <= 1'b1;
        redir_addr <= redirect_addr;
      end else if (fetch_ctl_change) begin
        redir_pend  <= 1'b0;
        issued_addr <= redir_addr;
      end
      if (fetch_done && !discard && fifo_full) overflow <= 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fetch_done && !discard && fifo_full));

endmodule

// File: tb/tb_fetch_queue.sv
// Drives fetch_queue with a fetch_unit stub and checks it against a queue-based model.
module tb_fetch_queue;
  import mmix_defs::*;

  localparam int DEPTH = 4;
  localparam int S_IDLE = 0, S_BUSY = 1, S_COOL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable, fetch_ctl_change;
  logic [63:0] fetch_next_addr;
  logic        fetch_done;
  fetch        fetch_head;
  logic        redirect;
  logic [63:0] redirect_addr;
  logic        out_valid, out_ready;
  fetch        out_head;
  logic [7:0]  out_op, out_x, out_y, out_z;
  logic        out_imm;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .fetch_enable(fetch_enable), .fetch_ctl_change(fetch_ctl_change),
    .fetch_next_addr(fetch_next_addr), .fetch_done(fetch_done), .fetch_head(fetch_head),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_head(out_head),
    .out_op(out_op), .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_imm(out_imm),
    .count(count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Model state: expected queue contents plus the fetch_unit stub.
  fetch        q[$];
  logic [63:0] popped[$];
  int          epoch, cur_epoch, st, lat, min_lat, max_lat, inst_mode, ctl_issues;
  logic [63:0] pc, cur_loc, exp_addr;
  logic        expect_ctl;

  function automatic fetch make_head(input logic [63:0] loc);
    fetch h;
    h.loc       = loc;
    h.interrupt = '0;
    case (inst_mode)
      0: h.inst = 32'h8C010203;
      1: begin
        h.inst = {SWYM, 24'h0};
        h.interrupt[PX_BIT] = 1'b1;
      end
      default: begin
        h.inst = (loc[31:0] * 32'h9E3779B1) ^ 32'h5A5A1234;
        h.interrupt = (loc[5:2] == 4'hF) ? 8'h02 : 8'h00;
      end
    endcase
    return h;
  endfunction

  // One cycle: called at a negedge, returns at the next negedge.
  task automatic step(input logic rdy, input logic redir, input logic [63:0] raddr);
    logic exp_valid, exp_pop, exp_en, exp_ctl;
    int   qafter;
    out_ready     = rdy;
    redirect      = redir;
    redirect_addr = raddr;
    fetch_done    = (st == S_BUSY && lat == 0);
    fetch_head    = fetch_done ? make_head(cur_loc) : '0;
    #1;
    exp_valid = (q.size() != 0) && !redir && !expect_ctl;
    exp_pop   = exp_valid && rdy;
    qafter    = q.size() - (exp_pop ? 1 : 0);
    exp_en    = (st == S_IDLE) && !redir && (expect_ctl || qafter <= DEPTH - 2);
    exp_ctl   = exp_en && expect_ctl;
    check_val("count", count, q.size());
    check_val("out_valid", out_valid, exp_valid);
    check_val("fetch_enable", fetch_enable, exp_en);
    check_val("ctl_change", fetch_ctl_change, exp_ctl);
    if (exp_ctl) check_val("next_addr", fetch_next_addr, exp_addr);
    if (exp_valid) begin
      check_val("out_head", out_head, q[0]);
      check_val("out_op", out_op, q[0].inst[31:24]);
      check_val("out_x", out_x, q[0].inst[23:16]);
      check_val("out_y", out_y, q[0].inst[15:8]);
      check_val("out_z", out_z, q[0].inst[7:0]);
      check_val("out_imm", out_imm, q[0].inst[24]);
      if (inst_mode == 1) begin
        check_val("irq_px", out_head.interrupt[PX_BIT], 1'b1);
        check_val("swym_op", out_op, SWYM);
      end
    end
    if (exp_pop) begin
      popped.push_back(q[0].loc);
      void'(q.pop_front());
    end
    if (fetch_done && cur_epoch == epoch && !redir) q.push_back(fetch_head);
    if (exp_ctl) expect_ctl = 1'b0;
    if (redir) begin
      q.delete();
      epoch++;
      expect_ctl = 1'b1;
      exp_addr   = raddr;
    end
    case (st)
      S_IDLE: if (fetch_enable) begin
        if (fetch_ctl_change) begin
          cur_loc = fetch_next_addr;
          ctl_issues++;
        end else begin
          cur_loc = pc;
        end
        pc        = cur_loc + 64'd4;
        cur_epoch = epoch;
        lat       = $urandom_range(max_lat, min_lat);
        st        = S_BUSY;
      end
      S_BUSY: if (lat == 0) st = S_COOL; else lat--;
      default: st = S_IDLE;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; fetch_done = 1'b0; out_ready = 1'b0;
    fetch_head = '0; redirect_addr = '0;
    #1;
    check_val("rst_enable", fetch_enable, 1'b0);
    check_val("rst_valid", out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_val("rst_count", count, 3'd0);
    check_val("rst_next_addr", fetch_next_addr, 64'd0);
    check_val("rst_ctl", fetch_ctl_change, 1'b0);
    reset = 1'b0;
    q.delete(); st = S_IDLE; lat = 0; pc = 64'h100; cur_loc = '0;
    epoch = 0; cur_epoch = 0; expect_ctl = 1'b0; exp_addr = '0;
    #1;
    check_val("post_rst_count", count, 3'd0);
    check_val("post_rst_valid", out_valid, 1'b0);
    check_val("post_rst_enable", fetch_enable, 1'b1);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!(st == S_BUSY && lat >= 1) && n < 50) begin
      step(1'b1, 1'b0, '0);
      n++;
    end
    if (n >= 50) check_val("wait_busy_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int   maxcnt, c0, n;
    logic stale_seen;
    logic [63:0] stale_loc;
    reset = 1'b1; redirect = 1'b0; fetch_done = 1'b0; out_ready = 1'b0;
    fetch_head = '0; redirect_addr = '0;
    inst_mode = 0; min_lat = 0; max_lat = 0; ctl_issues = 0;
    @(negedge clk);
    do_reset();

    // Straight line, dispatch always ready.
    popped.delete();
    repeat (12) step(1'b1, 1'b0, '0);
    check_val("sl_count", popped.size() >= 3, 1'b1);
    if (popped.size() >= 3) begin
      check_val("sl_loc0", popped[0], 64'h100);
      check_val("sl_loc1", popped[1], 64'h104);
      check_val("sl_loc2", popped[2], 64'h108);
    end

    // Backpressure fills to DEPTH-1 and holds.
    maxcnt = 0;
    repeat (20) begin
      step(1'b0, 1'b0, '0);
      if (int'(count) > maxcnt) maxcnt = int'(count);
    end
    check_val("bp_max_count", maxcnt, 3);
    check_val("bp_enable_low", fetch_enable, 1'b0);
    check_val("bp_overflow", dut.overflow, 1'b0);
    popped.delete();
    repeat (20) step(1'b1, 1'b0, '0);
    check_val("bp_drained", popped.size() >= 3, 1'b1);
    for (int i = 0; i + 1 < popped.size() && i < 4; i++)
      check_val("bp_order", popped[i+1], popped[i] + 64'd4);

    // Redirect with a fetch in flight.
    min_lat = 2; max_lat = 2;
    wait_busy();
    stale_loc = cur_loc;
    c0 = ctl_issues;
    step(1'b1, 1'b1, 64'h2000);
    check_val("rd_flush_count", count, 3'd0);
    popped.delete();
    repeat (15) step(1'b1, 1'b0, '0);
    check_val("rd_issues", ctl_issues - c0, 1);
    check_val("rd_first_loc", (popped.size() > 0) ? popped[0] : 64'h0, 64'h2000);
    stale_seen = 1'b0;
    foreach (popped[i]) if (popped[i] == stale_loc) stale_seen = 1'b1;
    check_val("rd_stale_hidden", stale_seen, 1'b0);

    // Redirect coincident with a pop and a fetch_done.
    n = 0;
    while (!(q.size() > 0 && st == S_BUSY && lat == 0) && n < 60) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    if (n >= 60) check_val("co_wait_timeout", 1'b0, 1'b1);
    step(1'b1, 1'b1, 64'h5000);
    check_val("co_count", count, 3'd0);
    repeat (10) step(1'b1, 1'b0, '0);

    // Back-to-back redirects: last address wins, single issue.
    wait_busy();
    c0 = ctl_issues;
    step(1'b1, 1'b1, 64'h3000);
    step(1'b1, 1'b1, 64'h4000);
    popped.delete();
    repeat (15) step(1'b1, 1'b0, '0);
    check_val("dr_issues", ctl_issues - c0, 1);
    check_val("dr_first_loc", (popped.size() > 0) ? popped[0] : 64'h0, 64'h4000);

    // Interrupt pass-through.
    inst_mode = 1; min_lat = 0; max_lat = 0;
    repeat (10) step(1'b1, 1'b0, '0);

    // Randomised traffic.
    inst_mode = 2; min_lat = 0; max_lat = 3;
    repeat (1500) step(($urandom % 10) < 7, ($urandom % 40) == 0,
                       {32'h0, $urandom} & ~64'h3);
    check_val("rand_overflow", dut.overflow, 1'b0);

    // Reset with two entries queued.
    inst_mode = 0; min_lat = 0; max_lat = 0;
    n = 0;
    while (q.size() < 2 && n < 40) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    if (n >= 40) check_val("rst2_wait_timeout", 1'b0, 1'b1);
    check_val("rst2_queued", count, 3'd2);
    do_reset();
    repeat (5) step(1'b1, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
